uart_cmd_wrapper: RTL and testbench



---
 rtl/uart_cmd_wrapper.sv | 217 +++++++++++++++++++++
 tb/tb_uart_cmd_wrapper.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_wrapper.sv
// rtl/uart_cmd_wrapper.sv - 3-byte UART command receiver with response transmit.
// Optional inter-byte frame timeout enabled by defining CMD_TIMEOUT_EN.

module uart #(
  parameter int BAUD_CYC = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rx_rdy,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       tx_done
);
  localparam int BW = $clog2(BAUD_CYC);

  logic [9:0]    tx_shft;
  logic [3:0]    tx_cnt;
  logic [BW-1:0] tx_baud;
  logic          tx_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shft <= '1;
      tx_cnt  <= '0;
      tx_baud <= '0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else if (trmt) begin
      tx_shft <= {1'b1, tx_data, 1'b0};
      tx_cnt  <= '0;
      tx_baud <= '0;
      tx_busy <= 1'b1;
      tx_done <= 1'b0;
    end else if (tx_busy) begin
      if (tx_baud == BW'(BAUD_CYC - 1)) begin
        tx_baud <= '0;
        tx_shft <= {1'b1, tx_shft[9:1]};
        if (tx_cnt == 4'd9) begin
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
        end else begin
          tx_cnt <= tx_cnt + 4'd1;
        end
      end else begin
        tx_baud <= tx_baud + 1'b1;
      end
    end
  end

  assign TX = tx_shft[0];

  logic          rx_ff1, rx_ff2, rx_busy, rx_start, rx_smpl;
  logic [3:0]    rx_cnt;
  logic [BW-1:0] rx_baud;
  logic [7:0]    rx_shft;

  assign rx_start = !rx_busy && !rx_ff2;
  assign rx_smpl  = rx_busy && (rx_baud == '0);

  // First sample lands mid start bit; the start bit is shifted out past bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1  <= 1'b1;
      rx_ff2  <= 1'b1;
      rx_busy <= 1'b0;
      rx_cnt  <= '0;
      rx_baud <= '0;
      rx_shft <= '0;
      rx_rdy  <= 1'b0;
    end else begin
      rx_ff1 <= RX;
      rx_ff2 <= rx_ff1;
      if (rx_start) begin
        rx_busy <= 1'b1;
        rx_cnt  <= '0;
        rx_baud <= BW'(BAUD_CYC / 2 - 1);
      end else if (rx_smpl) begin
        rx_baud <= BW'(BAUD_CYC - 1);
        if (rx_cnt != 4'd9) rx_shft <= {rx_ff2, rx_shft[7:1]};
        if (rx_cnt == 4'd9) rx_busy <= 1'b0;
        else rx_cnt <= rx_cnt + 4'd1;
      end else if (rx_busy) begin
        rx_baud <= rx_baud - 1'b1;
      end
      if (rx_smpl && rx_cnt == 4'd9) rx_rdy <= 1'b1;
      else if (clr_rx_rdy || rx_start) rx_rdy <= 1'b0;
    end
  end

  assign rx_data = rx_shft;
endmodule

module uart_cmd_wrapper #(
  parameter int BAUD_CYC = 434
`ifdef CMD_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 100000
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        frame_err
);
  typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO} state_t;
  state_t state, state_nxt;

  logic [7:0] rx_data, tx_data, cmd_shdw, hi_shdw, tx_hold;
  logic       rx_rdy, clr_rx_rdy, trmt, tx_done, busy;
  logic       ld_cmd, ld_hi, ld_out, drop, tmo_hit;

  uart #(.BAUD_CYC(BAUD_CYC)) u_uart (
    .clk(clk), .rst_n(rst_n), .RX(RX), .clr_rx_rdy(clr_rx_rdy),
    .trmt(trmt), .tx_data(tx_data), .TX(TX), .rx_data(rx_data),
    .rx_rdy(rx_rdy), .tx_done(tx_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_CMD;
    else state <= state_nxt;
  end

  // An arriving byte takes priority over a timeout in the same cycle.
  always_comb begin
    state_nxt  = state;
    clr_rx_rdy = 1'b0;
    ld_cmd     = 1'b0;
    ld_hi      = 1'b0;
    ld_out     = 1'b0;
    drop       = 1'b0;
    case (state)
      WAIT_CMD: if (rx_rdy) begin
        clr_rx_rdy = 1'b1; ld_cmd = 1'b1; state_nxt = WAIT_HI;
      end
      WAIT_HI: if (rx_rdy) begin
        clr_rx_rdy = 1'b1; ld_hi = 1'b1; state_nxt = WAIT_LO;
      end else if (tmo_hit) begin
        drop = 1'b1; state_nxt = WAIT_CMD;
      end
      WAIT_LO: if (rx_rdy) begin
        clr_rx_rdy = 1'b1; ld_out = 1'b1; state_nxt = WAIT_CMD;
      end else if (tmo_hit) begin
        drop = 1'b1; state_nxt = WAIT_CMD;
      end
      default: state_nxt = WAIT_CMD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_shdw <= '0;
      hi_shdw  <= '0;
      cmd      <= '0;
      data     <= '0;
      cmd_rdy  <= 1'b0;
    end else begin
      if (ld_cmd) cmd_shdw <= rx_data;
      else if (drop) cmd_shdw <= '0;
      if (ld_hi) hi_shdw <= rx_data;
      else if (drop) hi_shdw <= '0;
      if (ld_out) begin
        cmd  <= cmd_shdw;
        data <= {hi_shdw, rx_data};
      end
      if (ld_out) cmd_rdy <= 1'b1;
      else if (ld_cmd || clr_cmd_rdy) cmd_rdy <= 1'b0;
    end
  end

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state != WAIT_CMD) && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= drop;
      if (state == WAIT_CMD || rx_rdy || tmo_hit) tmo_cnt <= '0;
      else tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign frame_err = 1'b0;
`endif

  assign trmt      = send_resp && !busy;
  assign tx_data   = busy ? tx_hold : resp;
  assign resp_sent = busy && tx_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      tx_hold <= '0;
    end else if (trmt) begin
      busy    <= 1'b1;
      tx_hold <= resp;
    end else if (resp_sent) begin
      busy <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// tb/tb_uart_cmd_wrapper.sv - table-driven bench for uart_cmd_wrapper.
`timescale 1ns/1ps

module tb_uart_cmd_wrapper;
  localparam int BAUD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;
  logic        frame_err;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  uart_cmd_wrapper #(
    .BAUD_CYC(BAUD)
`ifdef CMD_TIMEOUT_EN
    , .TIMEOUT_CYC(64)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .data(data),
    .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .resp(resp),
    .send_resp(send_resp), .resp_sent(resp_sent), .frame_err(frame_err)
  );

  typedef struct {
    logic [7:0]  b0, b1, b2;
    bit          clr_on_last;
    bit          ack_after;
    logic [7:0]  exp_cmd;
    logic [15:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] frm;
    frm = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = frm[i];
      repeat (BAUD) @(negedge clk);
    end
  endtask

  task automatic wait_rdy(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (cmd_rdy) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  vec_t vecs[5];
  bit seen;
  int cnt;
  logic [7:0]  prev_cmd;
  logic [15:0] prev_data;
  logic [9:0]  exp_tx;

  initial begin
    vecs[0] = '{8'h02, 8'h12, 8'h34, 1'b0, 1'b1, 8'h02, 16'h1234};
    vecs[1] = '{8'h05, 8'hAB, 8'hCD, 1'b0, 1'b0, 8'h05, 16'hABCD};
    vecs[2] = '{8'h06, 8'h00, 8'h01, 1'b0, 1'b1, 8'h06, 16'h0001};
    vecs[3] = '{8'h11, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h11, 16'hFF00};
    vecs[4] = '{8'hA0, 8'h5A, 8'hC3, 1'b0, 1'b1, 8'hA0, 16'h5AC3};

    repeat (3) @(negedge clk);
    chk("reset_cmd", {24'd0, cmd}, 32'h00);
    chk("reset_data", {16'd0, data}, 32'h0000);
    chk("reset_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    chk("reset_tx", {31'd0, TX}, 32'd1);
    chk("reset_resp_sent", {31'd0, resp_sent}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    prev_cmd = 8'h00;
    prev_data = 16'h0000;
    for (int v = 0; v < 5; v++) begin
      send_byte(vecs[v].b0);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_rdy_low_first", v), {31'd0, cmd_rdy}, 32'd0);
      chk($sformatf("v%0d_cmd_stable", v), {24'd0, cmd}, {24'd0, prev_cmd});
      send_byte(vecs[v].b1);
      chk($sformatf("v%0d_data_stable", v), {16'd0, data}, {16'd0, prev_data});
      if (vecs[v].clr_on_last) clr_cmd_rdy = 1'b1;
      send_byte(vecs[v].b2);
      wait_rdy(seen);
      clr_cmd_rdy = 1'b0;
      chk($sformatf("v%0d_cmd_rdy", v), {31'd0, seen}, 32'd1);
      chk($sformatf("v%0d_cmd", v), {24'd0, cmd}, {24'd0, vecs[v].exp_cmd});
      chk($sformatf("v%0d_data", v), {16'd0, data}, {16'd0, vecs[v].exp_data});
      if (vecs[v].ack_after) begin
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        chk($sformatf("v%0d_ack_clears", v), {31'd0, cmd_rdy}, 32'd0);
        chk($sformatf("v%0d_ack_cmd_held", v), {24'd0, cmd}, {24'd0, vecs[v].exp_cmd});
        chk($sformatf("v%0d_ack_data_held", v), {16'd0, data}, {16'd0, vecs[v].exp_data});
      end
      prev_cmd = vecs[v].exp_cmd;
      prev_data = vecs[v].exp_data;
    end

    // Response A5 on TX, with a second request injected mid-frame.
    exp_tx = {1'b1, 8'hA5, 1'b0};
    resp = 8'hA5;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    resp = 8'h00;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) repeat (BAUD) begin
        @(negedge clk);
        send_resp = 1'b0;
      end
      chk($sformatf("tx_bit%0d", i), {31'd0, TX}, {31'd0, exp_tx[i]});
      if (i == 4) send_resp = 1'b1;
    end
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (resp_sent) cnt++;
    end
    chk("resp_sent_pulses", cnt, 1);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!TX) cnt++;
    end
    chk("tx_idle_after", cnt, 0);

    // Reset in the middle of a frame.
    send_byte(8'h02);
    send_byte(8'h12);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_cmd", {24'd0, cmd}, 32'h00);
    chk("midrst_data", {16'd0, data}, 32'h0000);
    chk("midrst_tx", {31'd0, TX}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'h07);
    send_byte(8'h00);
    send_byte(8'h10);
    wait_rdy(seen);
    chk("postrst_rdy", {31'd0, seen}, 32'd1);
    chk("postrst_cmd", {24'd0, cmd}, 32'h07);
    chk("postrst_data", {16'd0, data}, 32'h0010);

    // Long gap inside a frame.
    send_byte(8'h05);
    send_byte(8'hAB);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_err) cnt++;
    end
    chk("gap_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
`ifdef CMD_TIMEOUT_EN
    chk("gap_frame_err", cnt, 1);
    send_byte(8'h06);
    send_byte(8'h00);
    send_byte(8'h01);
    wait_rdy(seen);
    chk("gap_rdy", {31'd0, seen}, 32'd1);
    chk("gap_cmd", {24'd0, cmd}, 32'h06);
    chk("gap_data", {16'd0, data}, 32'h0001);
`else
    chk("gap_frame_err", cnt, 0);
    send_byte(8'hCD);
    wait_rdy(seen);
    chk("gap_rdy", {31'd0, seen}, 32'd1);
    chk("gap_cmd", {24'd0, cmd}, 32'h05);
    chk("gap_data", {16'd0, data}, 32'hABCD);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
